// File: rtl/fall_pkg.sv
// Purpose: shared definitions for the falling-character engine (game states, ASCII constants, saturating add).
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fall_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  // Enter key; the front end turns it into the start pulse.
  localparam logic [7:0] ASCII_ENTER = 8'h0D;

  // Adds inc to val and clamps the result at max_val.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] inc,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, val} + {1'b0, inc};
    if (sum > {1'b0, max_val}) return max_val;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/lane_match_picker.sv
// Purpose: picks the lane a key press removes: active, same char, lowest on screen (largest y), lowest index on ties.
// Latency: combinational.
// Backpressure: none.
// Ports: active/char_vec/y_vec per-lane state, key_ascii pressed key; hit = some lane matches, hit_lane = winner.
module lane_match_picker #(
  parameter int NUM_LANES = 8,
  parameter int Y_W       = 10,
  parameter int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0]          active,
  input  logic [NUM_LANES-1:0][7:0]     char_vec,
  input  logic [NUM_LANES-1:0][Y_W-1:0] y_vec,
  input  logic [7:0]                    key_ascii,
  output logic                          hit,
  output logic [LANE_W-1:0]             hit_lane
);

  logic [Y_W-1:0] best_y;

  // Ascending scan with a strict compare: an equal y never displaces an
  // earlier winner, which gives the lowest-index tiebreak.
  always_comb begin
    hit      = 1'b0;
    hit_lane = '0;
    best_y   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (active[i] && (char_vec[i] == key_ascii) && (!hit || (y_vec[i] > best_y))) begin
        hit      = 1'b1;
        hit_lane = LANE_W'(i);
        best_y   = y_vec[i];
      end
    end
  end

endmodule

// File: rtl/fall_lane_engine.sv
// Purpose: NUM_LANES falling-character lanes plus the IDLE/PLAY/OVER game FSM, score and miss counters.
// Latency: lane/score/miss state updates on the next clk edge; rd_* read port has 1-cycle latency.
// Backpressure: spawn_ready (combinational) drops when not in PLAY or the target lane is occupied; the generator retries.
// Ports: start/tick pulses; spawn_valid/ready + lane/char/speed; key_valid + key_ascii;
//        rd_lane -> rd_active/rd_char/rd_y; score, misses, state, game_over for the HUD.
// Build option: define WRONG_KEY_PENALTY_EN to count an unmatched key press in PLAY as a miss.
module fall_lane_engine
  import fall_pkg::*;
#(
  parameter int NUM_LANES  = 8,
  parameter int Y_W        = 10,
  parameter int SPEED_W    = 3,
  parameter int BOTTOM     = 480,
  parameter int SCORE_W    = 8,
  parameter int MAX_MISSES = 3,
  parameter int LANE_W     = $clog2(NUM_LANES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               tick,
  input  logic               spawn_valid,
  output logic               spawn_ready,
  input  logic [LANE_W-1:0]  spawn_lane,
  input  logic [7:0]         spawn_char,
  input  logic [SPEED_W-1:0] spawn_speed,
  input  logic               key_valid,
  input  logic [7:0]         key_ascii,
  input  logic [LANE_W-1:0]  rd_lane,
  output logic               rd_active,
  output logic [7:0]         rd_char,
  output logic [Y_W-1:0]     rd_y,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic [1:0]         state,
  output logic               game_over
);

  localparam logic [Y_W:0]       BOTTOM_V = (Y_W+1)'(BOTTOM);
  localparam logic [SCORE_W-1:0] MAX_M    = SCORE_W'(MAX_MISSES);
  localparam logic [31:0]        SAT_MAX  = 32'((64'd1 << SCORE_W) - 64'd1);

  state_t                              state_q, state_d;
  logic [NUM_LANES-1:0]                active_q, active_d;
  logic [NUM_LANES-1:0][7:0]           char_q, char_d;
  logic [NUM_LANES-1:0][Y_W-1:0]       y_q, y_d;
  logic [NUM_LANES-1:0][SPEED_W-1:0]   speed_q, speed_d;
  logic [SCORE_W-1:0]                  score_q, score_d;
  logic [SCORE_W-1:0]                  misses_q, misses_d;

  logic                                hit;
  logic [LANE_W-1:0]                   hit_lane;
  logic [7:0]                          miss_cnt;
  logic [Y_W:0]                        y_sum;
  logic                                clear_all;
  logic                                spawn_lane_ok;
  logic                                rd_lane_ok;

  lane_match_picker #(
    .NUM_LANES (NUM_LANES),
    .Y_W       (Y_W),
    .LANE_W    (LANE_W)
  ) u_picker (
    .active    (active_q),
    .char_vec  (char_q),
    .y_vec     (y_q),
    .key_ascii (key_ascii),
    .hit       (hit),
    .hit_lane  (hit_lane)
  );

  // Lane indices beyond NUM_LANES exist only when NUM_LANES is not a power of two.
  assign spawn_lane_ok = 32'(spawn_lane) < NUM_LANES;
  assign rd_lane_ok    = 32'(rd_lane) < NUM_LANES;
  assign spawn_ready   = (state_q == ST_PLAY) && spawn_lane_ok && !active_q[spawn_lane];

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    char_d    = char_q;
    y_d       = y_q;
    speed_d   = speed_q;
    score_d   = score_q;
    misses_d  = misses_q;
    miss_cnt  = '0;
    y_sum     = '0;
    clear_all = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d   = ST_PLAY;
          score_d   = '0;
          misses_d  = '0;
          clear_all = 1'b1;
        end
      end

      ST_PLAY: begin
        // Key removal is applied first so a lane typed on the same cycle
        // it would have crossed BOTTOM is neither moved nor missed.
        if (key_valid && hit) begin
          active_d[hit_lane] = 1'b0;
          score_d            = SCORE_W'(sat_inc(32'(score_q), 32'd1, SAT_MAX));
        end
`ifdef WRONG_KEY_PENALTY_EN
        if (key_valid && !hit) begin
          miss_cnt = miss_cnt + 8'd1;
        end
`endif
        if (tick) begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (active_d[i]) begin
              y_sum = {1'b0, y_q[i]} + (Y_W+1)'(speed_q[i]);
              if (y_sum >= BOTTOM_V) begin
                active_d[i] = 1'b0;
                miss_cnt    = miss_cnt + 8'd1;
              end else begin
                y_d[i] = y_sum[Y_W-1:0];
              end
            end
          end
        end
        // The spawn target was inactive, so the tick loop above never touched it.
        if (spawn_valid && spawn_ready) begin
          active_d[spawn_lane] = 1'b1;
          y_d[spawn_lane]      = '0;
          char_d[spawn_lane]   = spawn_char;
          speed_d[spawn_lane]  = (spawn_speed == '0) ? SPEED_W'(1) : spawn_speed;
        end
        misses_d = SCORE_W'(sat_inc(32'(misses_q), 32'(miss_cnt), SAT_MAX));
        if (misses_d >= MAX_M) begin
          state_d   = ST_OVER;
          clear_all = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (clear_all) begin
      active_d = '0;
      char_d   = '0;
      y_d      = '0;
      speed_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
      char_q   <= '0;
      y_q      <= '0;
      speed_q  <= '0;
      score_q  <= '0;
      misses_q <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      char_q   <= char_d;
      y_q      <= y_d;
      speed_q  <= speed_d;
      score_q  <= score_d;
      misses_q <= misses_d;
    end
  end

  // Renderer read port: registers the lane state as it stood after the previous edge.
  always_ff @(posedge clk) begin
    if (!rst_n || !rd_lane_ok) begin
      rd_active <= 1'b0;
      rd_char   <= '0;
      rd_y      <= '0;
    end else begin
      rd_active <= active_q[rd_lane];
      rd_char   <= char_q[rd_lane];
      rd_y      <= y_q[rd_lane];
    end
  end

  assign score     = score_q;
  assign misses    = misses_q;
  assign state     = state_q;
  assign game_over = (state_q == ST_OVER);

endmodule

// File: doc/fall_lane_engine.md
Name: fall_lane_engine

Overview:
Parametrised falling-character engine for the typing game. Holds NUM_LANES independent lanes, each carrying one character with its own vertical position and speed. Accepts spawn requests from the random generator and key codes from the PS/2 front end, and owns the IDLE/PLAY/OVER game FSM. Exposes a registered per-lane read port for the VGA renderer, plus score, miss and state outputs for the HUD.

Parameters:
NUM_LANES, 8, number of lanes (columns); 2..64
Y_W, 10, vertical position width in pixels
SPEED_W, 3, per-lane speed width (pixels per tick)
BOTTOM, 480, y at or beyond which a character is missed
SCORE_W, 8, score and miss counter width
MAX_MISSES, 3, miss count that ends the game
LANE_W, $clog2(NUM_LANES), lane index width (derived)

Ports:
clk  in  1  single system clock
rst_n  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; the Enter key
tick  in  1  one-cycle descent strobe; frame-rate derived
spawn_valid  in  1  spawn request
spawn_ready  out  1  spawn accepted this cycle when high with valid
spawn_lane  in  LANE_W  target lane
spawn_char  in  8  ASCII code
spawn_speed  in  SPEED_W  pixels per tick; 0 is promoted to 1
key_valid  in  1  one-cycle pulse per key make
key_ascii  in  8  pressed key ASCII
rd_lane  in  LANE_W  renderer lane select
rd_active  out  1  lane occupied (registered)
rd_char  out  8  lane character (registered)
rd_y  out  Y_W  lane top y (registered)
score  out  SCORE_W  characters typed correctly
misses  out  SCORE_W  characters missed
state  out  2  0=IDLE, 1=PLAY, 2=OVER
game_over  out  1  high while state==OVER

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; all lanes inactive; char, y and speed=0; score=0; misses=0; rd_* outputs=0; spawn_ready=0.
- FSM transitions: IDLE -start-> PLAY. PLAY -(misses reaches MAX_MISSES)-> OVER. OVER -start-> PLAY. Entering PLAY clears score, misses and all lanes in the same edge.
- Entering OVER clears all lanes. score and misses hold their values until the next PLAY entry.
- spawn_ready is combinational: state==PLAY and active[spawn_lane]==0. On accept: active=1, y=0, char=spawn_char, speed=max(spawn_speed,1).
- Spawn is never accepted in IDLE or OVER.
- tick in PLAY: for each active lane, y_next = y + speed, computed at Y_W+1 bits. If y_next >= BOTTOM, the lane goes inactive and misses increments (saturating). Several lanes missing on one tick add their count in one step.
- key_valid in PLAY: the matching lane is the active lane whose char==key_ascii and which has the largest y. Ties go to the lowest index. That lane goes inactive and score increments (saturating at all-ones). No match means no change.
- key_valid in IDLE or OVER is ignored.
- Same lane hit by tick and key in one cycle: removal wins; no miss is counted and no y update happens.
- Same lane targeted by spawn while it is occupied: spawn_ready=0, so the spawn is not accepted; the generator must retry.
- Misses crossing MAX_MISSES: the OVER transition happens on that same edge.
- start during PLAY: ignored.
- Read port: 1-cycle latency. rd_* reflects lane state as of the previous edge, after that edge's updates.
- score and misses are registered; they update on the edge following the causing event's sample.

Optional Feature:
WRONG_KEY_PENALTY_EN
- Defined: a key_valid in PLAY with no matching lane increments misses (saturating) and can trigger OVER.
- Undefined: unmatched keys are ignored.

Decomposition:
- Package fall_pkg holds the state encoding (ST_IDLE/ST_PLAY/ST_OVER), the ASCII_ENTER constant, and the saturating-increment function.
- Sub-module lane_match_picker is combinational. Inputs: active, char and y vectors plus key_ascii. Outputs: hit and hit_lane (largest y, lowest-index tiebreak).

Test Plan:
- Reset then start: state 0→1, score=0, misses=0; spawn lane 2 'A' speed 3, then 160 ticks → y reaches 480, lane inactive, misses=1.
- Lanes 1 ('B', y=100) and 5 ('B', y=300), key 'B' → lane 5 cleared, lane 1 kept, score=1. Second 'B' → lane 1 cleared, score=2.
- Lanes 0 and 3 both 'C' at equal y, key 'C' → lane 0 cleared only.
- Lane 4 'D' at y=477 speed 3; tick and key 'D' in the same cycle → lane cleared, score+1, misses unchanged.
- MAX_MISSES=3: three lanes reach BOTTOM on one tick → misses=3, state=OVER, all lanes inactive, spawn_ready=0. start → PLAY, score=0, misses=0.
- Spawn to an occupied lane 6 → spawn_ready=0, lane 6 char unchanged. With WRONG_KEY_PENALTY_EN, key 'Z' with no 'Z' lane → misses+1; without it, no change.
